// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide datapath units: the sequencing
// state encoding, Booth digit codes and the default operand width.
package mul_div_pkg;

   // Default operand width; the divider uses the same value for its operands.
   localparam int MUL_WIDTH = 32;

   // Sequencing states of the multi-cycle units.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Radix-4 Booth digit values: 0, +M, +2M, -M, -2M.
   typedef enum logic [2:0] {
      DIG_ZERO = 3'd0,
      DIG_P1   = 3'd1,
      DIG_P2   = 3'd2,
      DIG_N1   = 3'd3,
      DIG_N2   = 3'd4
   } digit_t;

   // Map a 3-bit window {q(i+1), q(i), q(i-1)} to its Booth digit.
   function automatic digit_t booth_digit(input logic [2:0] window);
      digit_t d;
      case (window)
         3'b001, 3'b010: d = DIG_P1;
         3'b011:         d = DIG_P2;
         3'b100:         d = DIG_N2;
         3'b101, 3'b110: d = DIG_N1;
         default:        d = DIG_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: turns the low three multiplier bits into the
// control flags of the partial-product selector (zero, double, negate).
module booth_recode
   import mul_div_pkg::*;
(
   input  logic [2:0] window,
   output logic       zero,
   output logic       two,
   output logic       neg
);

   digit_t digit;

   // Decode the window into a digit, then split the digit into selector flags.
   always_comb begin
      digit = booth_digit(window);
      zero  = (digit == DIG_ZERO);
      two   = (digit == DIG_P2) || (digit == DIG_N2);
      neg   = (digit == DIG_N1) || (digit == DIG_N2);
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed multiplier, radix-4 Booth, one recoded digit per clock.
// The control unit pulses start, operands are captured on the accepting edge,
// busy stays high for WIDTH/2 cycles, then done pulses for one cycle with the
// 2*WIDTH-bit product presented as hi/lo. WIDTH must be even.
//
// Handshake: start is only honoured in IDLE or FIN (start during RUN is
// dropped, nothing queues); done is a one-cycle pulse and hi/lo hold their
// value until the next done pulse. busy/done are decoded from the state
// register only, so there is no combinational path from start.
module booth_mul_seq
   import mul_div_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
)(
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int ITER = WIDTH / 2;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   state_t           state;
   state_t           state_nx;

   logic [WIDTH-1:0] m_reg;     // multiplicand
   logic [WIDTH:0]   q_reg;     // multiplier with q(-1) appended at bit 0
   logic [WIDTH+1:0] acc;       // partial product, two guard bits for +/-2M
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last;
   logic             rec_zero;
   logic             rec_two;
   logic             rec_neg;
   logic [WIDTH+1:0] m_ext;
   logic [WIDTH+1:0] addend;
   logic [WIDTH+1:0] sum;
   logic [WIDTH+1:0] acc_nx;
   logic [WIDTH:0]   q_nx;

   assign accept = start && ((state == IDLE) || (state == FIN));
   assign last   = (cnt == CW'(ITER - 1));
   assign busy   = (state == RUN);
   assign done   = (state == FIN);

   booth_recode u_recode (
      .window (q_reg[2:0]),
      .zero   (rec_zero),
      .two    (rec_two),
      .neg    (rec_neg)
   );

   // One Booth step: select 0/M/2M, negate if needed, add, then shift the
   // combined {acc, q} right by two bits arithmetically.
   always_comb begin
      m_ext  = {{2{m_reg[WIDTH-1]}}, m_reg};
      addend = '0;
      if (!rec_zero) begin
         addend = rec_two ? (m_ext << 1) : m_ext;
      end
      if (rec_neg) begin
         addend = -addend;
      end
      sum    = acc + addend;
      acc_nx = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
      q_nx   = {sum[1:0], q_reg[WIDTH:2]};
   end

   // Next-state logic of the sequencer.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = FIN;
         FIN:     state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register; clr aborts any operation immediately.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operand capture, iteration datapath and result registers. The result is
   // written on the final RUN edge so hi/lo are valid in the same cycle done is.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         m_reg <= '0;
         q_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (accept) begin
         m_reg <= a;
         q_reg <= {b, 1'b0};
         acc   <= '0;
         cnt   <= '0;
      end else if (state == RUN) begin
         acc <= acc_nx;
         q_reg <= q_nx;
         cnt <= cnt + CW'(1);
         if (last) begin
            hi <= acc_nx[WIDTH-1:0];
            lo <= q_nx[WIDTH:1];
         end
      end
   end

endmodule
